// File: rtl/cdb_arbiter.sv
// CDB writeback arbiter: per-FU result FIFOs, round-robin broadcast, issue backpressure.
// Optional macro CDB_BYPASS_EN: lanes may go straight to the CDB when every FIFO is empty.
module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PREG_WIDTH = 6,
    parameter int ROB_WIDTH  = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_FU-1:0]                fu_valid,
    input  logic [NUM_FU*PREG_WIDTH-1:0]     fu_pd,
    input  logic [NUM_FU*ROB_WIDTH-1:0]      fu_rob_idx,
    input  logic [NUM_FU*DATA_WIDTH-1:0]     fu_data,
    output logic [NUM_FU-1:0]                fu_full,
    input  logic                             flush,
    output logic                             cdb_valid,
    output logic [PREG_WIDTH-1:0]            cdb_pd,
    output logic [ROB_WIDTH-1:0]             cdb_rob_idx,
    output logic [DATA_WIDTH-1:0]            cdb_data,
    output logic                             overflow_err
);

    localparam int ENTRY_W = PREG_WIDTH + ROB_WIDTH + DATA_WIDTH;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int RR_W    = $clog2(NUM_FU);

    logic [ENTRY_W-1:0] mem_r   [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0]   head_r  [NUM_FU];
    logic [PTR_W-1:0]   tail_r  [NUM_FU];
    logic [CNT_W-1:0]   count_r [NUM_FU];
    logic [RR_W-1:0]    rr_ptr_r;
    logic               overflow_r;

    logic [ENTRY_W-1:0] in_entry_s [NUM_FU];
    logic [ENTRY_W-1:0] out_entry_s;
    logic [NUM_FU-1:0]  req_s;
    logic [NUM_FU-1:0]  pop_s;
    logic [NUM_FU-1:0]  push_s;
    logic [NUM_FU-1:0]  drop_s;
    logic [NUM_FU-1:0]  push_ok_s;
    logic               bypass_s;
    logic               gnt_found_s;
    logic               gnt_valid_s;
    logic [RR_W-1:0]    gnt_idx_s;

    // Pack each lane's incoming result into a FIFO entry
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            in_entry_s[i] = {fu_pd[i*PREG_WIDTH +: PREG_WIDTH],
                             fu_rob_idx[i*ROB_WIDTH +: ROB_WIDTH],
                             fu_data[i*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    // Round-robin search starting at rr_ptr; bypass lanes compete only when all FIFOs are empty
    always_comb begin
        int cand;
        cand        = 0;
        bypass_s    = 1'b0;
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            req_s[i] = (count_r[i] != '0);
        end
`ifdef CDB_BYPASS_EN
        if (req_s == '0) begin
            req_s    = fu_valid;
            bypass_s = 1'b1;
        end else begin
            bypass_s = 1'b0;
        end
`endif
        for (int k = 0; k < NUM_FU; k++) begin
            cand = (int'(rr_ptr_r) + k) % NUM_FU;
            if (!gnt_found_s && req_s[cand]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = RR_W'(cand);
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
        gnt_valid_s = gnt_found_s && !flush;
    end

    // Drive the CDB from the winner, zeroing the payload when nothing is granted
    always_comb begin
        if (bypass_s) begin
            out_entry_s = in_entry_s[gnt_idx_s];
        end else begin
            out_entry_s = mem_r[gnt_idx_s][head_r[gnt_idx_s]];
        end
        cdb_valid = gnt_valid_s;
        if (gnt_valid_s) begin
            {cdb_pd, cdb_rob_idx, cdb_data} = out_entry_s;
        end else begin
            {cdb_pd, cdb_rob_idx, cdb_data} = '0;
        end
    end

    // Per-FU push/pop decisions; a full FIFO accepts a push only when popped the same cycle
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            pop_s[i]     = gnt_valid_s && (gnt_idx_s == RR_W'(i)) && !bypass_s;
            push_s[i]    = fu_valid[i] && !flush &&
                           !(gnt_valid_s && bypass_s && (gnt_idx_s == RR_W'(i)));
            drop_s[i]    = push_s[i] && (count_r[i] == CNT_W'(FIFO_DEPTH)) && !pop_s[i];
            push_ok_s[i] = push_s[i] && !drop_s[i];
            fu_full[i]   = (count_r[i] >= CNT_W'(FIFO_DEPTH - 1));
        end
        overflow_err = overflow_r;
    end

    // FIFO storage; contents need no reset since counts gate every read
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push_ok_s[i]) begin
                mem_r[i][tail_r[i]] <= in_entry_s[i];
            end
        end
    end

    // Pointers, counts, round-robin pointer and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                head_r[i]  <= '0;
                tail_r[i]  <= '0;
                count_r[i] <= '0;
            end
            rr_ptr_r   <= '0;
            overflow_r <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                head_r[i]  <= '0;
                tail_r[i]  <= '0;
                count_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push_ok_s[i]) begin
                    tail_r[i] <= (tail_r[i] == PTR_W'(FIFO_DEPTH - 1)) ? '0 : tail_r[i] + PTR_W'(1);
                end
                if (pop_s[i]) begin
                    head_r[i] <= (head_r[i] == PTR_W'(FIFO_DEPTH - 1)) ? '0 : head_r[i] + PTR_W'(1);
                end
                case ({push_ok_s[i], pop_s[i]})
                    2'b10:   count_r[i] <= count_r[i] + CNT_W'(1);
                    2'b01:   count_r[i] <= count_r[i] - CNT_W'(1);
                    default: count_r[i] <= count_r[i];
                endcase
            end
            if (gnt_valid_s) begin
                rr_ptr_r <= (gnt_idx_s == RR_W'(NUM_FU - 1)) ? '0 : gnt_idx_s + RR_W'(1);
            end
            if (|drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized self-checking bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int PW = 6;
    localparam int RW = 5;
    localparam int D  = 2;
    localparam int EW = PW + RW + DW;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      fu_valid;
    logic [N*PW-1:0]   fu_pd;
    logic [N*RW-1:0]   fu_rob_idx;
    logic [N*DW-1:0]   fu_data;
    logic [N-1:0]      fu_full;
    logic              flush;
    logic              cdb_valid;
    logic [PW-1:0]     cdb_pd;
    logic [RW-1:0]     cdb_rob_idx;
    logic [DW-1:0]     cdb_data;
    logic              overflow_err;

    cdb_arbiter #(.NUM_FU(N), .DATA_WIDTH(DW), .PREG_WIDTH(PW), .ROB_WIDTH(RW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .fu_valid(fu_valid), .fu_pd(fu_pd), .fu_rob_idx(fu_rob_idx),
        .fu_data(fu_data), .fu_full(fu_full), .flush(flush), .cdb_valid(cdb_valid),
        .cdb_pd(cdb_pd), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: one queue per FU, round-robin pointer, sticky overflow
    logic [EW-1:0] q [N][$];
    int            rr_m;
    bit            ovf_m;
    logic [EW-1:0] in_e [N];
    bit            hold_payload = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_full();
        logic [N-1:0] f;
        for (int i = 0; i < N; i++) f[i] = (q[i].size() >= D - 1);
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) q[i].delete();
    endtask

    // One clock cycle: drive at negedge, check outputs, then advance the model
    task automatic cycle(input logic [N-1:0] vld, input logic fl);
        int            g;
        int            idx;
        bit            any;
        bit            byp;
        bit            req;
        logic [EW-1:0] exp_e;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!hold_payload) in_e[i] = {PW'($urandom), RW'($urandom), DW'($urandom)};
            fu_pd[i*PW +: PW]      = in_e[i][EW-1 -: PW];
            fu_rob_idx[i*RW +: RW] = in_e[i][DW +: RW];
            fu_data[i*DW +: DW]    = in_e[i][DW-1:0];
        end
        fu_valid = vld;
        flush    = fl;
        #1;
        g   = -1;
        any = 1'b0;
        byp = 1'b0;
        for (int i = 0; i < N; i++) if (q[i].size() > 0) any = 1'b1;
        if (!fl) begin
            for (int k = 0; k < N; k++) begin
                idx = (rr_m + k) % N;
                req = any ? (q[idx].size() > 0) : (BYP && vld[idx]);
                if (req && g < 0) g = idx;
            end
        end
        if (g >= 0 && !any) byp = 1'b1;
        exp_e = '0;
        if (g >= 0) exp_e = byp ? in_e[g] : q[g][0];
        check("cdb_valid", 64'(cdb_valid), 64'(g >= 0));
        check("cdb_payload", 64'({cdb_pd, cdb_rob_idx, cdb_data}), 64'(exp_e));
        check("fu_full", 64'(fu_full), 64'(model_full()));
        check("overflow_err", 64'(overflow_err), 64'(ovf_m));
        if (fl) begin
            model_clear();
        end else begin
            if (g >= 0) begin
                if (!byp) void'(q[g].pop_front());
                rr_m = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (vld[i] && !(byp && g == i)) begin
                    if (q[i].size() < D) q[i].push_back(in_e[i]);
                    else ovf_m = 1'b1;
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cdb_valid"}, 64'(cdb_valid), 64'd0);
        check({tag, "_cdb_payload"}, 64'({cdb_pd, cdb_rob_idx, cdb_data}), 64'd0);
        check({tag, "_fu_full"}, 64'(fu_full), 64'd0);
        check({tag, "_overflow"}, 64'(overflow_err), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        fu_valid   = '0;
        flush      = 1'b0;
        fu_pd      = '0;
        fu_rob_idx = '0;
        fu_data    = '0;
        rr_m       = 0;
        ovf_m      = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Single result from FU1
        hold_payload = 1'b1;
        for (int i = 0; i < N; i++) in_e[i] = '0;
        in_e[1] = {6'd5, 5'd3, 32'hDEADBEEF};
        cycle(4'b0010, 1'b0);
        hold_payload = 1'b0;
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        // Contention: all FUs at once, then drain
        cycle(4'b1111, 1'b0);
        repeat (5) cycle(4'b0000, 1'b0);

        // Fairness between FU0 and FU2 honouring backpressure
        repeat (24) cycle(4'b0101 & ~model_full(), 1'b0);
        repeat (3) cycle(4'b0000, 1'b0);

        // Constrained random traffic with occasional flush
        repeat (300) cycle(N'($urandom) & ~model_full(), ($urandom_range(15) == 0));

        // Flush with buffered entries plus a same-cycle push
        cycle(4'b0111, 1'b0);
        cycle(4'b0111 & ~model_full(), 1'b0);
        cycle(4'b1000, 1'b1);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);

        // Backpressure ignored: overflow must be raised and stay sticky
        repeat (6) cycle(4'b1111, 1'b0);
        repeat (4) cycle(4'b0000, 1'b0);
        check("overflow_sticky", 64'(overflow_err), 64'd1);

        // Asynchronous reset while FIFOs hold data
        cycle(4'b1111, 1'b0);
        @(negedge clk);
        fu_valid = '0;
        flush    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_clear();
        rr_m  = 0;
        ovf_m = 1'b0;
        #1;
        rst = 1'b0;
        cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);

        // More random traffic after reset
        repeat (150) cycle(N'($urandom) & ~model_full(), ($urandom_range(31) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
